// File: rtl/router_port_demux.sv
// router_port_demux
//   Demultiplexes one serial router input onto one of N_OUT serial outputs.
//   A frame starts with an ADDR_W-bit destination (MSB first) and is followed
//   by PAD_CYCLES padding cycles. During padding the destination is claimed
//   through a busy handshake with the crossbar arbiter. A frame whose
//   destination stays busy for the whole padding period is dropped. Packets,
//   drops and protocol errors are counted in saturating counters.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous reset, active-high
//   din        serial data/address bit
//   valid_n    active-low data valid
//   frame_n    active-low frame
//   dest_busy  per-output busy flag from the arbiter (1 = owned elsewhere)
//   dout       per-output serial data (registered)
//   valido_n   per-output active-low valid (registered)
//   frameo_n   per-output active-low frame (registered)
//   claim      one-hot ownership request/hold towards the arbiter
//   addr_o     destination of the current packet
//   pkt_cnt    packets delivered
//   drop_cnt   packets dropped for contention
//   err_cnt    protocol errors (frame_n high during address or padding)
module router_port_demux #(
    parameter int unsigned N_OUT      = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned PAD_CYCLES = 5,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              din,
    input  logic              valid_n,
    input  logic              frame_n,
    input  logic [N_OUT-1:0]  dest_busy,
    output logic [N_OUT-1:0]  dout,
    output logic [N_OUT-1:0]  valido_n,
    output logic [N_OUT-1:0]  frameo_n,
    output logic [N_OUT-1:0]  claim,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned BCNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam logic [3:0] PadInit = 4'(PAD_CYCLES);
    localparam logic [N_OUT-1:0] PortZero = N_OUT'(1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StPad,
        StData,
        StDrop
    } state_e;

    state_e             r_state, w_state_next;
    logic [ADDR_W-1:0]  r_shift, w_shift_next, w_shift_in;
    logic [BCNT_W-1:0]  r_bcnt, w_bcnt_next;
    logic [3:0]         r_pad, w_pad_next;
    logic [ADDR_W-1:0]  r_addr, w_addr_next;
    logic [N_OUT-1:0]   r_claim, w_claim_next;
    logic [N_OUT-1:0]   r_dout, w_dout_next;
    logic [N_OUT-1:0]   r_valido_n, w_valido_n_next;
    logic [N_OUT-1:0]   r_frameo_n, w_frameo_n_next;
    logic [CNT_W-1:0]   r_pkt, w_pkt_next;
    logic [CNT_W-1:0]   r_drop, w_drop_next;
    logic [CNT_W-1:0]   r_err, w_err_next;
    logic               r_pkt_done, w_pkt_done_next;
    logic               w_granted;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bcnt_next     = r_bcnt;
        w_pad_next      = r_pad;
        w_addr_next     = r_addr;
        w_claim_next    = r_claim;
        w_dout_next     = '0;
        w_valido_n_next = '1;
        w_frameo_n_next = '1;
        w_drop_next     = r_drop;
        w_err_next      = r_err;
        w_pkt_done_next = 1'b0;
        w_granted       = 1'b0;
        // Shift register keeps only the low ADDR_W bits of {old, new}.
        w_shift_in      = ADDR_W'({r_shift, din});
        // The delivery is counted in the cycle after the last bit, together
        // with the claim release.
        w_pkt_next      = r_pkt_done ? sat_inc(r_pkt) : r_pkt;

        unique case (r_state)
            StIdle: begin
                // Releases the claim held over from the previous packet's last bit.
                w_claim_next = '0;
                if (!frame_n) begin
                    w_shift_next = ADDR_W'(din);
                    w_bcnt_next  = BCNT_W'(1);
                    if (ADDR_W == 1) begin
                        w_addr_next  = ADDR_W'(din);
                        w_pad_next   = PadInit;
                        w_state_next = StPad;
                    end else begin
                        w_state_next = StAddr;
                    end
                end
            end

            StAddr: begin
                if (frame_n) begin
                    w_claim_next = '0;
                    w_err_next   = sat_inc(r_err);
                    w_state_next = StIdle;
                end else begin
                    w_shift_next = w_shift_in;
                    w_bcnt_next  = BCNT_W'(r_bcnt + 1'b1);
                    if (r_bcnt == BCNT_W'(ADDR_W - 1)) begin
                        w_addr_next  = w_shift_in;
                        w_pad_next   = PadInit;
                        w_state_next = StPad;
                    end
                end
            end

            StPad: begin
                if (frame_n) begin
                    w_claim_next = '0;
                    w_err_next   = sat_inc(r_err);
                    w_state_next = StIdle;
                end else begin
                    w_pad_next = r_pad - 4'd1;
                    w_granted  = (r_claim != '0) || !dest_busy[r_addr];
                    if ((r_claim == '0) && !dest_busy[r_addr]) begin
                        w_claim_next = PortZero << r_addr;
                    end
                    if (r_pad == 4'd1) begin
                        if (w_granted) begin
                            w_state_next = StData;
                        end else begin
                            w_drop_next  = sat_inc(r_drop);
                            w_state_next = StDrop;
                        end
                    end
                end
            end

            StData: begin
                w_dout_next[r_addr]     = din & ~valid_n;
                w_valido_n_next[r_addr] = valid_n;
                // Frame only rises on the valid last bit; idle bits keep it low.
                w_frameo_n_next[r_addr] = frame_n & ~valid_n;
                if (frame_n && !valid_n) begin
                    w_pkt_done_next = 1'b1;
                    w_state_next    = StIdle;
                end
            end

            StDrop: begin
                if (frame_n && !valid_n) begin
                    w_state_next = StIdle;
                end
            end

            default: begin
                w_claim_next = '0;
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_bcnt     <= '0;
            r_pad      <= '0;
            r_addr     <= '0;
            r_claim    <= '0;
            r_dout     <= '0;
            r_valido_n <= '1;
            r_frameo_n <= '1;
            r_pkt      <= '0;
            r_drop     <= '0;
            r_err      <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bcnt     <= w_bcnt_next;
            r_pad      <= w_pad_next;
            r_addr     <= w_addr_next;
            r_claim    <= w_claim_next;
            r_dout     <= w_dout_next;
            r_valido_n <= w_valido_n_next;
            r_frameo_n <= w_frameo_n_next;
            r_pkt      <= w_pkt_next;
            r_drop     <= w_drop_next;
            r_err      <= w_err_next;
            r_pkt_done <= w_pkt_done_next;
        end
    end

    assign dout     = r_dout;
    assign valido_n = r_valido_n;
    assign frameo_n = r_frameo_n;
    assign claim    = r_claim;
    assign addr_o   = r_addr;
    assign pkt_cnt  = r_pkt;
    assign drop_cnt = r_drop;
    assign err_cnt  = r_err;

endmodule

// File: tb/tb_router_port_demux.sv
// tb_router_port_demux
//   Directed bench for router_port_demux. Each packet is described at
//   transaction level (address, per-pad-cycle busy pattern, data bits);
//   the generator turns it into per-cycle stimulus plus the outputs the
//   packet must produce, and every driven cycle is compared one edge later.
//   A few literal expectations pin the model at key points.
module tb_router_port_demux;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int P  = 5;
    localparam int CW = 8;

    typedef struct packed {
        logic         din;
        logic         vn;
        logic         fn;
        logic         rst;
        logic [N-1:0] busy;
    } stim_t;

    typedef struct packed {
        logic [N-1:0]  dout;
        logic [N-1:0]  vo;
        logic [N-1:0]  fo;
        logic [N-1:0]  claim;
        logic [AW-1:0] addr;
        logic [CW-1:0] pkt;
        logic [CW-1:0] drop;
        logic [CW-1:0] err;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          din;
    logic          valid_n;
    logic          frame_n;
    logic [N-1:0]  dest_busy;
    logic [N-1:0]  dout;
    logic [N-1:0]  valido_n;
    logic [N-1:0]  frameo_n;
    logic [N-1:0]  claim;
    logic [AW-1:0] addr_o;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] err_cnt;

    router_port_demux #(
        .N_OUT      (N),
        .ADDR_W     (AW),
        .PAD_CYCLES (P),
        .CNT_W      (CW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .din       (din),
        .valid_n   (valid_n),
        .frame_n   (frame_n),
        .dest_busy (dest_busy),
        .dout      (dout),
        .valido_n  (valido_n),
        .frameo_n  (frameo_n),
        .claim     (claim),
        .addr_o    (addr_o),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clock = ~clock;

    stim_t sq[$];
    exp_t  eq[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_cyc = 0;

    // Model of the observable state after each edge.
    logic [N-1:0]  m_claim;
    logic [AW-1:0] m_addr;
    logic [CW-1:0] m_pkt, m_drop, m_err;
    bit            m_release;

    function automatic logic [CW-1:0] msat(input logic [CW-1:0] v);
        int x;
        x = int'(v) + 1;
        if (x > (1 << CW) - 1) x = (1 << CW) - 1;
        return CW'(x);
    endfunction

    // A delivered packet releases its port and is counted one cycle after its last bit.
    task automatic pre();
        if (m_release) begin
            m_claim   = '0;
            m_pkt     = msat(m_pkt);
            m_release = 0;
        end
    endtask

    task automatic cyc(input logic d, input logic v, input logic f, input logic r,
                       input logic [N-1:0] busy, input logic [N-1:0] e_dout,
                       input logic [N-1:0] e_vo, input logic [N-1:0] e_fo);
        stim_t s;
        exp_t  e;
        s.din = d; s.vn = v; s.fn = f; s.rst = r; s.busy = busy;
        e.dout = e_dout; e.vo = e_vo; e.fo = e_fo; e.claim = m_claim;
        e.addr = m_addr; e.pkt = m_pkt; e.drop = m_drop; e.err = m_err;
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pre();
            cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, '1, '1);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            m_claim = '0; m_addr = '0; m_pkt = '0; m_drop = '0; m_err = '0;
            m_release = 0;
            cyc(1'b0, 1'b1, 1'b1, 1'b1, '0, '0, '1, '1);
        end
    endtask

    // err_at: header cycle index (address bits then pad cycles) where frame_n
    // rises; abort_at: data bit index where generation stops (for reset tests).
    task automatic send(input int addr, input logic [P-1:0] pbusy, input int nd,
                        input logic [15:0] dbits, input logic [15:0] dvn,
                        input int err_at, input int abort_at);
        logic [AW-1:0] a;
        logic [N-1:0]  oh;
        logic [N-1:0]  busy;
        logic          b, d, v, last;
        bit            dropped;
        a = AW'(addr);
        oh = '0;
        oh[a] = 1'b1;
        dropped = 0;
        for (int k = 0; k < AW; k++) begin
            pre();
            b = a[AW-1-k];
            if (err_at == k && k > 0) begin
                m_err = msat(m_err);
                m_claim = '0;
                cyc(b, 1'b0, 1'b1, 1'b0, '0, '0, '1, '1);
                return;
            end
            if (k == AW - 1) m_addr = a;
            cyc(b, 1'b0, 1'b0, 1'b0, '0, '0, '1, '1);
        end
        for (int p = 0; p < P; p++) begin
            pre();
            busy = pbusy[p] ? oh : '0;
            if (err_at == AW + p) begin
                m_err = msat(m_err);
                m_claim = '0;
                cyc(1'b1, 1'b0, 1'b1, 1'b0, busy, '0, '1, '1);
                return;
            end
            // Port is taken on the first free pad cycle and kept afterwards.
            if (m_claim == '0 && !pbusy[p]) m_claim = oh;
            if (p == P - 1 && m_claim == '0) begin
                dropped = 1;
                m_drop = msat(m_drop);
            end
            cyc(p[0], p[1], 1'b0, 1'b0, busy, '0, '1, '1);
        end
        for (int j = 0; j < nd; j++) begin
            if (j == abort_at) return;
            pre();
            last = (j == nd - 1);
            d = dbits[j];
            v = last ? 1'b0 : dvn[j];
            if (dropped) begin
                cyc(d, v, last, 1'b0, '0, '0, '1, '1);
            end else begin
                if (last) m_release = 1;
                cyc(d, v, last, 1'b0, '0, (d && !v) ? oh : '0, v ? '1 : ~oh,
                    last ? '1 : ~oh);
            end
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic compare_cycle();
        exp_t e;
        exp_t a;
        e = eq.pop_front();
        a.dout = dout; a.vo = valido_n; a.fo = frameo_n; a.claim = claim;
        a.addr = addr_o; a.pkt = pkt_cnt; a.drop = drop_cnt; a.err = err_cnt;
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL cycle%0d outputs: got dout=%h vo=%h fo=%h claim=%h addr=%h pkt=%0d drop=%0d err=%0d; expected dout=%h vo=%h fo=%h claim=%h addr=%h pkt=%0d drop=%0d err=%0d",
                     n_cyc, a.dout, a.vo, a.fo, a.claim, a.addr, a.pkt, a.drop, a.err,
                     e.dout, e.vo, e.fo, e.claim, e.addr, e.pkt, e.drop, e.err);
        end
    endtask

    // Drives n queued cycles (all when n < 0) and checks each one after its edge.
    task automatic run(input int n);
        stim_t s;
        int    k;
        k = 0;
        while (sq.size() > 0 && (n < 0 || k < n)) begin
            s = sq.pop_front();
            @(negedge clock);
            din = s.din; valid_n = s.vn; frame_n = s.fn; dest_busy = s.busy;
            if (s.rst && !reset_n) begin
                reset_n = 1'b1;
                #1;
                lit("async_rst_claim", 32'(claim), 32'h0);
                lit("async_rst_frameo", 32'(frameo_n), 32'hffff);
                lit("async_rst_dout", 32'(dout), 32'h0);
                lit("async_rst_pkt", 32'(pkt_cnt), 32'h0);
            end
            reset_n = s.rst;
            @(posedge clock);
            #1;
            compare_cycle();
            n_cyc++;
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1; din = 1'b0; valid_n = 1'b1; frame_n = 1'b1; dest_busy = '0;
        m_claim = '0; m_addr = '0; m_pkt = '0; m_drop = '0; m_err = '0; m_release = 0;

        do_reset(2);
        idle(2);
        run(-1);
        lit("reset_claim", 32'(claim), 32'h0);

        // Address 10, free destination, data 1,0,1,1.
        send(10, 5'b00000, 4, 16'b1101, 16'h0, -1, -1);
        idle(2);
        run(5);
        lit("t1_claim_pad2", 32'(claim), 32'h0400);
        run(-1);
        lit("t1_pkt", 32'(pkt_cnt), 32'd1);
        lit("t1_addr", 32'(addr_o), 32'd10);

        // Address 3, busy for the first three pad cycles.
        send(3, 5'b00111, 2, 16'b10, 16'h0, -1, -1);
        idle(2);
        run(AW + 3);
        lit("t2_claim_busy", 32'(claim), 32'h0);
        run(1);
        lit("t2_claim_pad4", 32'(claim), 32'h0008);
        run(-1);
        lit("t2_drop", 32'(drop_cnt), 32'd0);

        // Address 3 busy throughout: dropped; then address 5 back-to-back.
        send(3, 5'b11111, 3, 16'b101, 16'h0, -1, -1);
        send(5, 5'b00000, 3, 16'b011, 16'h0, -1, -1);
        idle(2);
        run(-1);
        lit("t3_drop", 32'(drop_cnt), 32'd1);
        lit("t3_pkt", 32'(pkt_cnt), 32'd3);

        // Idle bits 2 and 3 of 6.
        send(6, 5'b00000, 6, 16'b101011, 16'b000110, -1, -1);
        idle(2);
        run(-1);
        lit("t4_pkt", 32'(pkt_cnt), 32'd4);

        // Frame rises after two address bits, then during pad cycle 3.
        send(4, 5'b00000, 0, 16'h0, 16'h0, 2, -1);
        idle(1);
        send(9, 5'b00000, 0, 16'h0, 16'h0, AW + 2, -1);
        idle(2);
        run(-1);
        lit("err_cnt", 32'(err_cnt), 32'd2);
        lit("err_claim", 32'(claim), 32'h0);

        // Reset in the middle of the data phase.
        send(2, 5'b00000, 6, 16'h003f, 16'h0, -1, 3);
        do_reset(2);
        idle(2);
        run(-1);
        lit("rst_err", 32'(err_cnt), 32'd0);

        // Back-to-back 7 and 12, then 256 contention drops.
        send(7, 5'b00000, 2, 16'b01, 16'h0, -1, -1);
        send(12, 5'b00000, 2, 16'b10, 16'h0, -1, -1);
        for (int i = 0; i < 256; i++) begin
            send(i % N, 5'b11111, 1, 16'(i & 1), 16'h0, -1, -1);
        end
        idle(2);
        run(-1);
        lit("b2b_pkt", 32'(pkt_cnt), 32'd2);
        lit("drop_sat", 32'(drop_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
